repairval_rx_checker: RTL and testbench

//  Receive-side checker for MBINIT.REPAIRVAL. While the local partner FSM enables detection,
//  it compares deserialized valid-lane words against the VALTRAIN pattern.
//  It counts iterations and consecutive matches, then logs a pass/fail result.

---
 rtl/repairval_rx_checker_if.sv | 40 ++++
 rtl/repairval_rx_checker.sv | 132 +++++++++++++
 tb/tb_repairval_rx_checker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/repairval_rx_checker_if.sv
// Interface bundling the REPAIRVAL receive-checker control, data and result signals.
//   master : partner FSM / deserializer side; drives enable, words, stop; observes results
//   slave  : the checker; consumes enable, words, stop; drives results and counters
interface repairval_rx_checker_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             i_det_en;
  logic [7:0]       i_val_word;
  logic             i_val_word_valid;
  logic             i_stop;
  logic             o_VAL_Result_logged;
  logic             o_result_valid;
  logic             o_done_pulse;
  logic [CNT_W-1:0] o_iter_count;
  logic [CNT_W-1:0] o_err_count;

  modport master (
    output i_det_en,
    output i_val_word,
    output i_val_word_valid,
    output i_stop,
    input  o_VAL_Result_logged,
    input  o_result_valid,
    input  o_done_pulse,
    input  o_iter_count,
    input  o_err_count
  );

  modport slave (
    input  i_det_en,
    input  i_val_word,
    input  i_val_word_valid,
    input  i_stop,
    output o_VAL_Result_logged,
    output o_result_valid,
    output o_done_pulse,
    output o_iter_count,
    output o_err_count
  );
endinterface

// File: rtl/repairval_rx_checker.sv
// Receive-side checker for MBINIT.REPAIRVAL. While detection is enabled it compares each
// valid-lane word against the VALTRAIN pattern, counts words, mismatches and consecutive
// matches, and logs PASS once a long enough run of matches has been seen.
// Ports:
//   CLK  : clock
//   rst  : synchronous active-high reset
//   bus  : checker side of repairval_rx_checker_if (enable, word, word valid, stop in;
//          result, result valid, done pulse, iteration and error counts out)
module repairval_rx_checker #(
  parameter logic [7:0]  PATTERN       = 8'hF0,
  parameter int unsigned ITERATIONS    = 128,
  parameter int unsigned CONSEC_THRESH = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                 CLK,
  input  logic                 rst,
  repairval_rx_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] IterMax = CNT_W'(ITERATIONS);
  localparam logic [CNT_W-1:0] RunMax  = CNT_W'(CONSEC_THRESH);

  typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             pass_q, pass_d;
  logic             done_pulse_q, done_pulse_d;
  logic             word_match;

  assign word_match = (bus.i_val_word == PATTERN);

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    err_d        = err_q;
    run_d        = run_q;
    pass_d       = pass_q;
    done_pulse_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_det_en) begin
          state_d = StCheck;
          iter_d  = '0;
          err_d   = '0;
          run_d   = '0;
          pass_d  = 1'b0;
        end
      end

      StCheck: begin
        // Losing enable is an abort and outranks completion in the same cycle.
        if (!bus.i_det_en) begin
          state_d = StIdle;
          iter_d  = '0;
          err_d   = '0;
          run_d   = '0;
          pass_d  = 1'b0;
        end else begin
          // A word arriving together with stop is counted before completing.
          if (bus.i_val_word_valid) begin
            iter_d = iter_q + 1'b1;
            if (word_match) begin
              if (run_q < RunMax) begin
                run_d = run_q + 1'b1;
              end
              if (run_d == RunMax) begin
                pass_d = 1'b1;
              end
            end else begin
              run_d = '0;
              if (err_q != '1) begin
                err_d = err_q + 1'b1;
              end
            end
          end
          if ((iter_d == IterMax) || bus.i_stop) begin
            state_d      = StDone;
            done_pulse_d = 1'b1;
          end
        end
      end

      StDone: begin
        // Result is held until enable drops; a held-high enable never restarts.
        if (!bus.i_det_en) begin
          state_d = StIdle;
          iter_d  = '0;
          err_d   = '0;
          run_d   = '0;
          pass_d  = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        iter_d  = '0;
        err_d   = '0;
        run_d   = '0;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= StIdle;
      iter_q       <= '0;
      err_q        <= '0;
      run_q        <= '0;
      pass_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      err_q        <= err_d;
      run_q        <= run_d;
      pass_q       <= pass_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign bus.o_result_valid      = (state_q == StDone);
  assign bus.o_VAL_Result_logged = (state_q == StDone) & pass_q;
  assign bus.o_done_pulse        = done_pulse_q;
  assign bus.o_iter_count        = iter_q;
  assign bus.o_err_count         = err_q;

endmodule

// File: tb/tb_repairval_rx_checker.sv
// Directed bench for repairval_rx_checker: back-to-back pass, periodic-mismatch fail,
// early stop, abort, mid-burst reset, stop-without-words and gapped traffic with DONE noise.
module tb_repairval_rx_checker;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  repairval_rx_checker_if #(.CNT_W(8)) bus ();

  repairval_rx_checker #(
    .PATTERN       (8'hF0),
    .ITERATIONS    (128),
    .CONSEC_THRESH (16),
    .CNT_W         (8)
  ) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic stop);
    bus.i_val_word_valid = 1'b1;
    bus.i_val_word       = w;
    bus.i_stop           = stop;
    tick();
    bus.i_val_word_valid = 1'b0;
    bus.i_stop           = 1'b0;
  endtask

  initial begin
    int sent;
    int cycles;
    logic v;

    rst                  = 1'b1;
    bus.i_det_en         = 1'b0;
    bus.i_val_word       = 8'h00;
    bus.i_val_word_valid = 1'b0;
    bus.i_stop           = 1'b0;
    tick();
    tick();
    check("rst_rv",   32'(bus.o_result_valid), 32'd0);
    check("rst_res",  32'(bus.o_VAL_Result_logged), 32'd0);
    check("rst_done", 32'(bus.o_done_pulse), 32'd0);
    check("rst_iter", 32'(bus.o_iter_count), 32'd0);
    check("rst_err",  32'(bus.o_err_count), 32'd0);
    rst = 1'b0;
    // Stray traffic in IDLE must be ignored.
    send_word(8'h12, 1'b1);
    check("idle_ignore_iter", 32'(bus.o_iter_count), 32'd0);
    check("idle_ignore_rv",   32'(bus.o_result_valid), 32'd0);

    // 1: 128 matching words back-to-back.
    bus.i_det_en = 1'b1;
    tick();
    for (int i = 0; i < 128; i++) begin
      send_word(8'hF0, 1'b0);
      if (i == 126) check("t1_no_early_done", 32'(bus.o_done_pulse), 32'd0);
    end
    check("t1_done", 32'(bus.o_done_pulse), 32'd1);
    check("t1_rv",   32'(bus.o_result_valid), 32'd1);
    check("t1_pass", 32'(bus.o_VAL_Result_logged), 32'd1);
    check("t1_iter", 32'(bus.o_iter_count), 32'd128);
    check("t1_err",  32'(bus.o_err_count), 32'd0);
    tick();
    check("t1_pulse_once", 32'(bus.o_done_pulse), 32'd0);
    check("t1_rv_held",    32'(bus.o_result_valid), 32'd1);
    bus.i_det_en = 1'b0;
    tick();
    check("t1_exit_rv",   32'(bus.o_result_valid), 32'd0);
    check("t1_exit_res",  32'(bus.o_VAL_Result_logged), 32'd0);
    check("t1_exit_iter", 32'(bus.o_iter_count), 32'd0);

    // 2: 15 matches then one 8'hF1, repeated; runs top out at 15.
    bus.i_det_en = 1'b1;
    tick();
    for (int i = 0; i < 128; i++) begin
      send_word(((i % 16) == 15) ? 8'hF1 : 8'hF0, 1'b0);
    end
    check("t2_done", 32'(bus.o_done_pulse), 32'd1);
    check("t2_rv",   32'(bus.o_result_valid), 32'd1);
    check("t2_fail", 32'(bus.o_VAL_Result_logged), 32'd0);
    check("t2_iter", 32'(bus.o_iter_count), 32'd128);
    check("t2_err",  32'(bus.o_err_count), 32'd8);
    bus.i_det_en = 1'b0;
    tick();

    // 3: 100 mismatches, 16 matches, stop with the 16th match.
    bus.i_det_en = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) send_word(8'h0F, 1'b0);
    for (int i = 0; i < 15; i++) send_word(8'hF0, 1'b0);
    check("t3_no_early_done", 32'(bus.o_done_pulse), 32'd0);
    send_word(8'hF0, 1'b1);
    check("t3_done", 32'(bus.o_done_pulse), 32'd1);
    check("t3_pass", 32'(bus.o_VAL_Result_logged), 32'd1);
    check("t3_iter", 32'(bus.o_iter_count), 32'd116);
    check("t3_err",  32'(bus.o_err_count), 32'd100);
    bus.i_det_en = 1'b0;
    tick();

    // 4: abort after 50 words, then re-enable.
    bus.i_det_en = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) send_word(8'hF0, 1'b0);
    check("t4_iter50", 32'(bus.o_iter_count), 32'd50);
    bus.i_det_en = 1'b0;
    tick();
    check("t4_abort_done", 32'(bus.o_done_pulse), 32'd0);
    check("t4_abort_rv",   32'(bus.o_result_valid), 32'd0);
    check("t4_abort_iter", 32'(bus.o_iter_count), 32'd0);
    tick();
    check("t4_abort_rv2",  32'(bus.o_result_valid), 32'd0);
    bus.i_det_en = 1'b1;
    tick();
    send_word(8'hF0, 1'b0);
    check("t4_restart_iter", 32'(bus.o_iter_count), 32'd1);
    // Abort outranks completion: drop enable together with stop.
    bus.i_det_en = 1'b0;
    send_word(8'hF0, 1'b1);
    check("t4_abort_prio_done", 32'(bus.o_done_pulse), 32'd0);
    check("t4_abort_prio_rv",   32'(bus.o_result_valid), 32'd0);

    // 5: reset mid-CHECK, then stop with no words.
    bus.i_det_en = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) send_word(8'h33, 1'b0);
    check("t5_err10", 32'(bus.o_err_count), 32'd10);
    rst = 1'b1;
    tick();
    check("t5_rst_iter", 32'(bus.o_iter_count), 32'd0);
    check("t5_rst_err",  32'(bus.o_err_count), 32'd0);
    check("t5_rst_rv",   32'(bus.o_result_valid), 32'd0);
    check("t5_rst_done", 32'(bus.o_done_pulse), 32'd0);
    rst = 1'b0;
    tick();
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    check("t5_stop_done", 32'(bus.o_done_pulse), 32'd1);
    check("t5_stop_rv",   32'(bus.o_result_valid), 32'd1);
    check("t5_stop_fail", 32'(bus.o_VAL_Result_logged), 32'd0);
    check("t5_stop_iter", 32'(bus.o_iter_count), 32'd0);
    bus.i_det_en = 1'b0;
    tick();

    // 6: gapped all-match traffic, then extra words and stop while DONE.
    bus.i_det_en = 1'b1;
    tick();
    sent   = 0;
    cycles = 0;
    while (sent < 128 && cycles < 2000) begin
      v = 1'($urandom_range(0, 1));
      bus.i_val_word_valid = v;
      bus.i_val_word       = 8'hF0;
      tick();
      cycles++;
      if (v) sent++;
    end
    bus.i_val_word_valid = 1'b0;
    check("t6_budget", 32'(sent), 32'd128);
    check("t6_done",   32'(bus.o_done_pulse), 32'd1);
    for (int i = 0; i < 5; i++) send_word(8'hF0, 1'b0);
    send_word(8'h00, 1'b1);
    check("t6_iter", 32'(bus.o_iter_count), 32'd128);
    check("t6_err",  32'(bus.o_err_count), 32'd0);
    check("t6_pass", 32'(bus.o_VAL_Result_logged), 32'd1);
    check("t6_rv",   32'(bus.o_result_valid), 32'd1);
    check("t6_no_repulse", 32'(bus.o_done_pulse), 32'd0);
    bus.i_det_en = 1'b0;
    tick();
    check("t6_exit_rv", 32'(bus.o_result_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
